dlsc_pcie_s6_inbound_write: RTL and testbench
=============================================

DLSC_PCIE_S6_INBOUND_WRITE -- requirements
Module: dlsc_pcie_s6_inbound_write

Purpose: consumes inbound PCIe write command/payload streams; emits AXI-style write bursts (AW/W/B).

Interface
REQ-001 Parameters SHALL be: ADDR, default 32, AXI byte-address width (≤64); MAX_BURST, default 16, max beats per burst (power of 2, 1..16); MAX_OUTSTANDING, default 4, max unacknowledged bursts (power of 2, 1..16).
REQ-002 clk  in  1  single clock; all logic on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-004 wr_ready out 1; wr_valid in 1; wr_length in 10 (DWs, 0=1024); wr_be_last in 4; wr_be_first in 4; wr_addr in [63:2]; wr_bar in 7 (ignored).
REQ-005 wrp_ready out 1; wrp_valid in 1; wrp_last in 1 (ignored for framing); wrp_data in 32.
REQ-006 axi_aw_ready in 1; axi_aw_valid out 1; axi_aw_addr out ADDR; axi_aw_len out 4 (beats-1).
REQ-007 axi_w_ready in 1; axi_w_valid out 1; axi_w_last out 1; axi_w_data out 32; axi_w_strb out 4.
REQ-008 axi_b_ready out 1; axi_b_valid in 1; axi_b_resp in 2.
REQ-009 err out 1, one-cycle error pulse; present only per REQ-024.

Function
REQ-010 FSM states SHALL be IDLE, AW, W; a transfer occurs when valid and ready are both high on a clock edge.
REQ-011 IDLE: wr_ready=1; on wr_valid, latch command: remaining = (wr_length==0 ? 1024 : wr_length), addr = {wr_addr,2'b00} truncated to ADDR bits, first-flag=1; go to AW.
REQ-012 Burst beats = min(remaining, MAX_BURST - (addr[ADDR-side DW index] mod MAX_BURST)); bursts SHALL never cross a MAX_BURST*4-byte boundary, hence never a 4 KB boundary.
REQ-013 AW: axi_aw_valid=1 (registered) with axi_aw_addr/axi_aw_len for current burst, held stable until accepted; if outstanding count == MAX_OUTSTANDING, axi_aw_valid SHALL stay low. On accept: outstanding+1, go to W.
REQ-014 W: combinational pass-through, zero latency: axi_w_valid=wrp_valid, wrp_ready=axi_w_ready, axi_w_data=wrp_data; wrp_ready=0 in all other states.
REQ-015 axi_w_last=1 on the final beat of each burst, from beat counter.
REQ-016 axi_w_strb: first beat of request = wr_be_first; last beat of request (length>1) = wr_be_last; length 1 = wr_be_first only; all other beats 4'hF.
REQ-017 After final beat of a burst: addr += beats*4, remaining -= beats; go to AW if remaining≠0, else IDLE.
REQ-018 axi_b_ready SHALL be constantly 1; each B accept decrements outstanding; simultaneous AW accept and B accept SHALL leave count unchanged.
REQ-019 Address increment SHALL wrap modulo 2^ADDR with no error.
REQ-020 wrp_last SHALL not alter framing; framing is from wr_length only.

Reset
REQ-021 While rst_n=0: state=IDLE, outstanding=0, remaining=0, beat counter=0, axi_aw_valid=0, axi_aw_addr=0, axi_aw_len=0, wr_ready=0, err=0.
REQ-022 wr_ready SHALL rise in the first cycle after rst_n deasserts; axi_w_valid/wrp_ready are 0 since state is IDLE.
REQ-023 Reset mid-burst SHALL abandon the request; no beat is emitted after reset without a new wr command.

Configuration
REQ-024 Macro DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN: defined -> err port exists; pulses 1 cycle when B accepted with axi_b_resp≠2'b00. Undefined -> err port absent, axi_b_resp ignored; all else identical.

Verification
REQ-025 wr_length=1, addr=0x1000, be_first=4'h3 -> one AW addr 0x1000 len 0; one W strb 4'h3, last=1.
REQ-026 wr_length=0, addr=0x0 -> 64 AW bursts of len 15 at 0x0,0x40,...,0xFC0; 1024 W beats; strb 4'hF except first/last per BEs.
REQ-027 wr_length=20, addr=0x38, MAX_BURST=16 -> bursts: 0x38 len 1, 0x40 len 15, 0x80 len 1; first strb=be_first, final strb=be_last.
REQ-028 MAX_OUTSTANDING=4, B withheld -> exactly 4 AW accepted, axi_aw_valid low; one B -> fifth AW issued next cycle.
REQ-029 ERR_EN defined, B with resp 2'b10 -> err high exactly one cycle; undefined build compiles without err.
REQ-030 rst_n asserted mid-W with axi_w_ready random -> axi_aw_valid=0, wrp_ready=0 immediately; next command runs normally.

Source files
------------

// File: rtl/dlsc_pcie_s6_inbound_write.sv
// Inbound PCIe write to AXI write-burst bridge.
// Splits each write command into AXI bursts that never cross a MAX_BURST*4-byte
// boundary and passes payload DWs straight through onto the W channel.
// Optional feature: define DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN to add the err output,
// a one-cycle pulse for every B response with a non-OKAY resp code.
module dlsc_pcie_s6_inbound_write #(
  parameter int unsigned ADDR            = 32,
  parameter int unsigned MAX_BURST       = 16,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  // write command
  output logic            wr_ready,
  input  logic            wr_valid,
  input  logic [9:0]      wr_length,
  input  logic [3:0]      wr_be_last,
  input  logic [3:0]      wr_be_first,
  input  logic [63:2]     wr_addr,
  input  logic [6:0]      wr_bar,
  // write payload
  output logic            wrp_ready,
  input  logic            wrp_valid,
  input  logic            wrp_last,
  input  logic [31:0]     wrp_data,
  // AXI AW
  input  logic            axi_aw_ready,
  output logic            axi_aw_valid,
  output logic [ADDR-1:0] axi_aw_addr,
  output logic [3:0]      axi_aw_len,
  // AXI W
  input  logic            axi_w_ready,
  output logic            axi_w_valid,
  output logic            axi_w_last,
  output logic [31:0]     axi_w_data,
  output logic [3:0]      axi_w_strb,
  // AXI B
  output logic            axi_b_ready,
  input  logic            axi_b_valid,
  input  logic [1:0]      axi_b_resp
`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN
  ,
  output logic            err
`endif
);

  typedef enum logic [1:0] {StIdle, StAw, StW} state_e;

  state_e          state_q, state_d;
  logic [10:0]     remaining_q, remaining_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic            first_q, first_d;
  logic [4:0]      beats_q, beats_d;
  logic [4:0]      outstanding_q, outstanding_d;
  logic            aw_valid_q, aw_valid_d;
  logic [ADDR-1:0] aw_addr_q, aw_addr_d;
  logic [3:0]      aw_len_q, aw_len_d;
  logic [3:0]      be_first_q, be_first_d;
  logic [3:0]      be_last_q, be_last_d;
  logic            wr_ready_q, wr_ready_d;

  logic            aw_acc, w_acc, b_dec;
  logic [63:0]     cmd_addr;
  logic [ADDR-1:0] dw_idx;
  logic [4:0]      dw_off, room, burst_beats;

  assign cmd_addr = {wr_addr, 2'b00};

  // Beats left before the next MAX_BURST-aligned DW boundary, capped by what remains
  assign dw_idx      = addr_q >> 2;
  assign dw_off      = 5'(dw_idx & ADDR'(MAX_BURST - 1));
  assign room        = 5'(MAX_BURST) - dw_off;
  assign burst_beats = (remaining_q < 11'(room)) ? remaining_q[4:0] : room;

  assign aw_acc = aw_valid_q & axi_aw_ready;
  assign w_acc  = (state_q == StW) & wrp_valid & axi_w_ready;
  // Ignore a stray B when nothing is outstanding so the counter cannot wrap
  assign b_dec  = axi_b_valid & (outstanding_q != 5'd0);

  // Next-state logic: command latch, burst issue and per-beat bookkeeping
  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    addr_d        = addr_q;
    first_d       = first_q;
    beats_d       = beats_q;
    aw_addr_d     = aw_addr_q;
    aw_len_d      = aw_len_q;
    be_first_d    = be_first_q;
    be_last_d     = be_last_q;
    outstanding_d = outstanding_q;

    case (state_q)
      StIdle: begin
        if (wr_valid && wr_ready_q) begin
          remaining_d = (wr_length == 10'd0) ? 11'd1024 : {1'b0, wr_length};
          addr_d      = cmd_addr[ADDR-1:0];
          first_d     = 1'b1;
          be_first_d  = wr_be_first;
          be_last_d   = wr_be_last;
          state_d     = StAw;
        end
      end
      StAw: begin
        // addr_q/remaining_q are frozen here, so the AW fields stay stable
        aw_addr_d = addr_q;
        aw_len_d  = 4'(burst_beats - 5'd1);
        if (aw_acc) begin
          beats_d = burst_beats;
          state_d = StW;
        end
      end
      StW: begin
        if (w_acc) begin
          first_d     = 1'b0;
          addr_d      = addr_q + ADDR'(4);
          remaining_d = remaining_q - 11'd1;
          beats_d     = beats_q - 5'd1;
          if (beats_q == 5'd1) begin
            state_d = (remaining_q == 11'd1) ? StIdle : StAw;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    case ({aw_acc, b_dec})
      2'b10:   outstanding_d = outstanding_q + 5'd1;
      2'b01:   outstanding_d = outstanding_q - 5'd1;
      default: outstanding_d = outstanding_q;
    endcase
  end

  // AW valid rises one cycle after entering AW, once aw_addr_q/aw_len_q are loaded
  assign aw_valid_d = (state_q == StAw) && !aw_acc &&
                      (outstanding_d != 5'(MAX_OUTSTANDING));
  assign wr_ready_d = (state_d == StIdle);

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      remaining_q   <= '0;
      addr_q        <= '0;
      first_q       <= 1'b0;
      beats_q       <= '0;
      outstanding_q <= '0;
      aw_valid_q    <= 1'b0;
      aw_addr_q     <= '0;
      aw_len_q      <= '0;
      be_first_q    <= '0;
      be_last_q     <= '0;
      wr_ready_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      addr_q        <= addr_d;
      first_q       <= first_d;
      beats_q       <= beats_d;
      outstanding_q <= outstanding_d;
      aw_valid_q    <= aw_valid_d;
      aw_addr_q     <= aw_addr_d;
      aw_len_q      <= aw_len_d;
      be_first_q    <= be_first_d;
      be_last_q     <= be_last_d;
      wr_ready_q    <= wr_ready_d;
    end
  end

  assign wr_ready     = wr_ready_q;
  assign axi_aw_valid = aw_valid_q;
  assign axi_aw_addr  = aw_addr_q;
  assign axi_aw_len   = aw_len_q;
  assign axi_b_ready  = 1'b1;

  // Zero-latency payload pass-through while in W
  assign axi_w_valid = (state_q == StW) & wrp_valid;
  assign wrp_ready   = (state_q == StW) & axi_w_ready;
  assign axi_w_data  = wrp_data;
  assign axi_w_last  = (beats_q == 5'd1);
  // A single-DW request only ever uses the first-BE mask
  assign axi_w_strb  = first_q                  ? be_first_q :
                       (remaining_q == 11'd1)   ? be_last_q  : 4'hF;

`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN
  logic err_q;

  // Flag every accepted B with a non-OKAY response for one cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= axi_b_valid && (axi_b_resp != 2'b00);
    end
  end

  assign err = err_q;

  logic unused_in;
  assign unused_in = ^{wr_bar, wrp_last, cmd_addr};
`else
  logic unused_in;
  assign unused_in = ^{wr_bar, wrp_last, cmd_addr, axi_b_resp};
`endif

endmodule

// File: tb/tb_dlsc_pcie_s6_inbound_write.sv
// Directed bench for dlsc_pcie_s6_inbound_write (default parameters).
module tb_dlsc_pcie_s6_inbound_write;

  localparam int unsigned ADDR = 32;
  localparam int unsigned MAX_BURST = 16;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            wr_ready, wr_valid;
  logic [9:0]      wr_length;
  logic [3:0]      wr_be_last, wr_be_first;
  logic [63:2]     wr_addr;
  logic [6:0]      wr_bar;
  logic            wrp_ready, wrp_valid, wrp_last;
  logic [31:0]     wrp_data;
  logic            axi_aw_ready, axi_aw_valid;
  logic [ADDR-1:0] axi_aw_addr;
  logic [3:0]      axi_aw_len;
  logic            axi_w_ready, axi_w_valid, axi_w_last;
  logic [31:0]     axi_w_data;
  logic [3:0]      axi_w_strb;
  logic            axi_b_ready, axi_b_valid;
  logic [1:0]      axi_b_resp;
`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN
  logic            err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dlsc_pcie_s6_inbound_write #(
    .ADDR            (ADDR),
    .MAX_BURST       (MAX_BURST),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_ready     (wr_ready),
    .wr_valid     (wr_valid),
    .wr_length    (wr_length),
    .wr_be_last   (wr_be_last),
    .wr_be_first  (wr_be_first),
    .wr_addr      (wr_addr),
    .wr_bar       (wr_bar),
    .wrp_ready    (wrp_ready),
    .wrp_valid    (wrp_valid),
    .wrp_last     (wrp_last),
    .wrp_data     (wrp_data),
    .axi_aw_ready (axi_aw_ready),
    .axi_aw_valid (axi_aw_valid),
    .axi_aw_addr  (axi_aw_addr),
    .axi_aw_len   (axi_aw_len),
    .axi_w_ready  (axi_w_ready),
    .axi_w_valid  (axi_w_valid),
    .axi_w_last   (axi_w_last),
    .axi_w_data   (axi_w_data),
    .axi_w_strb   (axi_w_strb),
    .axi_b_ready  (axi_b_ready),
    .axi_b_valid  (axi_b_valid),
    .axi_b_resp   (axi_b_resp)
`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN
    ,
    .err          (err)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input int len, input logic [63:0] addr, input logic [3:0] bef,
                        input logic [3:0] bel);
    for (int i = 0; i < 20 && !wr_ready; i++) tick();
    chk("wr_ready", 64'(wr_ready), 64'd1);
    wr_valid    = 1'b1;
    wr_length   = 10'(len);
    wr_addr     = addr[63:2];
    wr_be_first = bef;
    wr_be_last  = bel;
    wr_bar      = 7'h55;
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic expect_aw(input logic [63:0] a, input int len);
    for (int i = 0; i < 50 && !axi_aw_valid; i++) tick();
    chk("aw_valid", 64'(axi_aw_valid), 64'd1);
    chk("aw_addr", 64'(axi_aw_addr), a);
    chk("aw_len", 64'(axi_aw_len), 64'(len));
    axi_aw_ready = 1'b1;
    tick();
    axi_aw_ready = 1'b0;
  endtask

  task automatic expect_w(input logic [3:0] strb, input logic last);
    logic [31:0] d;
    d = $urandom();
    wrp_valid = 1'b1;
    wrp_last  = 1'($urandom());
    wrp_data  = d;
    axi_w_ready = 1'b1;
    #1;
    chk("w_valid", 64'(axi_w_valid), 64'd1);
    chk("wrp_ready", 64'(wrp_ready), 64'd1);
    chk("w_data", 64'(axi_w_data), 64'(d));
    chk("w_strb", 64'(axi_w_strb), 64'(strb));
    chk("w_last", 64'(axi_w_last), 64'(last));
    @(posedge clk);
    #1;
    wrp_valid   = 1'b0;
    axi_w_ready = 1'b0;
  endtask

  task automatic full_beats(input int n);
    for (int i = 0; i < n; i++) expect_w(4'hF, i == n - 1);
  endtask

  task automatic send_b(input logic [1:0] resp);
    chk("b_ready", 64'(axi_b_ready), 64'd1);
    axi_b_valid = 1'b1;
    axi_b_resp  = resp;
    tick();
    axi_b_valid = 1'b0;
    axi_b_resp  = 2'b00;
  endtask

  // Reference burst splitter: one B answered per burst
  task automatic run_req(input int len, input logic [63:0] addr, input logic [3:0] bef,
                         input logic [3:0] bel);
    logic [63:0] a;
    int rem, idx, off, nb;
    logic [3:0] s;
    do_cmd(len, addr, bef, bel);
    a   = addr & 64'hFFFF_FFFC;
    rem = (len == 0) ? 1024 : len;
    idx = 0;
    while (rem > 0) begin
      off = int'((a >> 2) % 64'(MAX_BURST));
      nb  = int'(MAX_BURST) - off;
      if (rem < nb) nb = rem;
      expect_aw(a, nb - 1);
      for (int b = 0; b < nb; b++) begin
        if (idx == 0) s = bef;
        else if (idx == ((len == 0) ? 1023 : len - 1)) s = bel;
        else s = 4'hF;
        expect_w(s, b == nb - 1);
        idx++;
      end
      send_b(2'b00);
      a   = (a + 64'(nb * 4)) & 64'hFFFF_FFFF;
      rem = rem - nb;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    wr_valid = 1'b0; wr_length = '0; wr_be_last = '0; wr_be_first = '0;
    wr_addr = '0; wr_bar = '0;
    wrp_valid = 1'b1; wrp_last = 1'b0; wrp_data = '0;
    axi_aw_ready = 1'b0; axi_w_ready = 1'b1;
    axi_b_valid = 1'b0; axi_b_resp = 2'b00;

    // Reset state with W-side inputs active
    tick();
    tick();
    chk("rst wr_ready", 64'(wr_ready), 64'd0);
    chk("rst aw_valid", 64'(axi_aw_valid), 64'd0);
    chk("rst aw_addr", 64'(axi_aw_addr), 64'd0);
    chk("rst aw_len", 64'(axi_aw_len), 64'd0);
    chk("rst w_valid", 64'(axi_w_valid), 64'd0);
    chk("rst wrp_ready", 64'(wrp_ready), 64'd0);
    rst_n = 1'b1;
    tick();
    chk("post-rst wr_ready", 64'(wr_ready), 64'd1);
    chk("post-rst w_valid", 64'(axi_w_valid), 64'd0);
    wrp_valid = 1'b0; axi_w_ready = 1'b0;

    // Single DW at 0x1000
    do_cmd(1, 64'h1000, 4'h3, 4'hC);
    expect_aw(64'h1000, 0);
    // Payload stall: nothing forwarded while wrp_valid is low
    axi_w_ready = 1'b1;
    #1;
    chk("stall w_valid", 64'(axi_w_valid), 64'd0);
    tick();
    axi_w_ready = 1'b0;
    expect_w(4'h3, 1'b1);
    chk("single back idle", 64'(wr_ready), 64'd1);
    send_b(2'b00);

`ifdef DLSC_PCIE_S6_INBOUND_WRITE_ERR_EN
    chk("err idle", 64'(err), 64'd0);
    axi_b_valid = 1'b1; axi_b_resp = 2'b10;
    tick();
    axi_b_valid = 1'b0; axi_b_resp = 2'b00;
    chk("err pulse", 64'(err), 64'd1);
    tick();
    chk("err clear", 64'(err), 64'd0);
`endif

    // 20 DWs at 0x38: 2 + 16 + 2 beats
    do_cmd(20, 64'h38, 4'h1, 4'h8);
    expect_aw(64'h38, 1);
    expect_w(4'h1, 1'b0);
    expect_w(4'hF, 1'b1);
    expect_aw(64'h40, 15);
    full_beats(16);
    expect_aw(64'h80, 1);
    expect_w(4'hF, 1'b0);
    expect_w(4'h8, 1'b1);
    send_b(2'b00);
    send_b(2'b00);
    send_b(2'b00);

    // Address wrap at top of 32-bit space: two one-beat bursts
    run_req(2, 64'hFFFF_FFFC, 4'h6, 4'h9);

    // Length 0 = 1024 DWs from 0x0: 64 full bursts
    run_req(0, 64'h0, 4'h7, 4'hE);

    // Outstanding limit: 80 DWs, B withheld
    do_cmd(80, 64'h0, 4'hF, 4'hF);
    for (int k = 0; k < 4; k++) begin
      expect_aw(64'(k * 64), 15);
      full_beats(16);
    end
    tick(); tick(); tick();
    chk("limit aw_valid low", 64'(axi_aw_valid), 64'd0);
    axi_b_valid = 1'b1;
    tick();
    axi_b_valid = 1'b0;
    chk("fifth aw_valid", 64'(axi_aw_valid), 64'd1);
    chk("fifth aw_addr", 64'(axi_aw_addr), 64'h100);
    chk("fifth aw_len", 64'(axi_aw_len), 64'd15);
    // AW accept coincides with a B: count stays at 3
    axi_aw_ready = 1'b1; axi_b_valid = 1'b1;
    tick();
    axi_aw_ready = 1'b0; axi_b_valid = 1'b0;
    full_beats(16);
    // One more burst fits (count 4), the next must wait
    do_cmd(32, 64'h400, 4'hF, 4'hF);
    expect_aw(64'h400, 15);
    full_beats(16);
    tick(); tick(); tick();
    chk("limit2 aw_valid low", 64'(axi_aw_valid), 64'd0);
    send_b(2'b00);
    expect_aw(64'h440, 15);
    full_beats(16);
    for (int k = 0; k < 4; k++) send_b(2'b00);

    // Reset in the middle of a W burst
    do_cmd(4, 64'h200, 4'hF, 4'hF);
    expect_aw(64'h200, 3);
    expect_w(4'hF, 1'b0);
    wrp_valid = 1'b1; axi_w_ready = 1'($urandom()) | 1'b1;
    #1;
    chk("pre-rst w_valid", 64'(axi_w_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst aw_valid", 64'(axi_aw_valid), 64'd0);
    chk("midrst wrp_ready", 64'(wrp_ready), 64'd0);
    chk("midrst w_valid", 64'(axi_w_valid), 64'd0);
    chk("midrst wr_ready", 64'(wr_ready), 64'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rerst wr_ready", 64'(wr_ready), 64'd1);
    tick(); tick();
    chk("abandon w_valid", 64'(axi_w_valid), 64'd0);
    chk("abandon aw_valid", 64'(axi_aw_valid), 64'd0);
    wrp_valid = 1'b0; axi_w_ready = 1'b0;
    do_cmd(2, 64'h10, 4'h2, 4'h4);
    expect_aw(64'h10, 1);
    expect_w(4'h2, 1'b0);
    expect_w(4'h4, 1'b1);
    send_b(2'b00);
    chk("final wr_ready", 64'(wr_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
